// File: rtl/dsp_or_seq.sv
// dsp_or_seq: wide bitwise OR/AND/XOR/NOR run one 48-bit slice per clock.
// Operands are latched and zero-extended to lanes*48 bits, slices are
// processed by a single 48-bit logic lane, and the merged result is
// presented on y (truncated to width) with a valid/ready handshake.

// Single 48-bit logic lane: the only datapath the sequencer time-shares.
module dsp_or_seq_lane (
  input  logic [1:0]  op,
  input  logic [47:0] a,
  input  logic [47:0] b,
  output logic [47:0] y
);
  // Per-bit op decode: 0=OR 1=AND 2=XOR 3=NOR
  always_comb begin
    case (op)
      2'd0:    y = a | b;
      2'd1:    y = a & b;
      2'd2:    y = a ^ b;
      default: y = ~(a | b);
    endcase
  end
endmodule

module dsp_or_seq #(
  parameter int width = 96
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] y
);
  localparam int lanes = (width + 47) / 48;
  localparam int ext_w = lanes * 48;
  localparam int kw    = (lanes > 1) ? $clog2(lanes) : 1;

  if (width < 1 || width > 192) begin : g_width_chk
    $error("dsp_or_seq: width must be in 1..192");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [ext_w-1:0] a_q, b_q, res_q;
  logic [1:0]       op_q;
  logic [kw-1:0]    k;
  logic             last, accept;
  logic [47:0]      a_s, b_s, f_s;

  // in_ready is state-decoded, so accept has no path back to in_ready
  assign accept = (state == IDLE) && in_valid;
  assign last   = (k == kw'(lanes - 1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come from state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Select slice k of the latched operands
  always_comb begin
    a_s = a_q[47:0];
    b_s = b_q[47:0];
    for (int i = 0; i < lanes; i++) begin
      if (k == kw'(i)) begin
        a_s = a_q[i*48 +: 48];
        b_s = b_q[i*48 +: 48];
      end
    end
  end

  dsp_or_seq_lane u_lane (
    .op (op_q),
    .a  (a_s),
    .b  (b_s),
    .y  (f_s)
  );

  // Operand capture, slice counter and result merge; reset drops any
  // in-flight work so a partial result is never presented
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      k     <= '0;
      res_q <= '0;
    end else if (accept) begin
      a_q   <= ext_w'(a);
      b_q   <= ext_w'(b);
      op_q  <= op;
      k     <= '0;
      res_q <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < lanes; i++) begin
        if (k == kw'(i)) res_q[i*48 +: 48] <= f_s;
      end
      if (!last) k <= k + 1'b1;
    end
  end

  // Pad bits above width (all ones for NOR) are dropped here
  assign y = res_q[width-1:0];

endmodule
